interval_scheduler: RTL

Controller that sequences the countdown datapath through a programmed list of up to four intervals, e.g. work/rest cycles. It holds the interval table and issues load/run commands to the countdown datapath, which owns the secs/ten_secs/mins digits. It consumes the datapath's zero-reached pulse and drives the alarm enable: a short beep between intervals and a continuous alarm after the last one. It sits between the debounced switch pulses and the countdown/alarm blocks.

---
 rtl/timer_pkg.sv | 43 ++++
 rtl/beep_counter.sv | 28 ++
 rtl/interval_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer blocks:
// scheduler states, board clock rate, slot width and clamp helpers.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_BEEP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int TICKS_PER_SEC = 12000000;

    localparam int SLOT_W = 4;
    localparam logic [SLOT_W-1:0] MIN_MINS = 4'd1;
    localparam logic [SLOT_W-1:0] MAX_MINS = 4'd9;

    localparam logic [2:0] MIN_COUNT = 3'd1;
    localparam logic [2:0] MAX_COUNT = 3'd4;

    // A zero-minute interval would finish immediately, so it is bumped to one.
    function automatic logic [SLOT_W-1:0] clamp_mins(input logic [SLOT_W-1:0] value);
        if (value < MIN_MINS)
            return MIN_MINS;
        else if (value > MAX_MINS)
            return MAX_MINS;
        else
            return value;
    endfunction

    // The table always holds at least one and at most four active slots.
    function automatic logic [2:0] clamp_count(input logic [2:0] value);
        if (value < MIN_COUNT)
            return MIN_COUNT;
        else if (value > MAX_COUNT)
            return MAX_COUNT;
        else
            return value;
    endfunction

endpackage

// File: rtl/beep_counter.sv
// Load/clear down-counter with a zero flag; times the beep between intervals.
module beep_counter #(
    parameter int WIDTH = 25
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Clear beats load beats decrement; the count parks at zero rather than wrapping.
    always_ff @(posedge CLK) begin
        if (reset || clear)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/interval_scheduler.sv
// Sequences the countdown datapath through a programmed list of up to four
// intervals, beeping between them and alarming continuously after the last.
module interval_scheduler
    import timer_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int TICKS_PER_SEC = timer_pkg::TICKS_PER_SEC,
    parameter int BEEP_SECS     = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        prog_we,
    input  logic [1:0]  prog_addr,
    input  logic [3:0]  prog_mins,
    input  logic [2:0]  prog_count,
    input  logic        start,
    input  logic        cancel,
    input  logic        timer_done,
    output logic        load,
    output logic [3:0]  load_mins,
    output logic        run,
    output logic        alarm_on,
    output logic [1:0]  slot_idx,
    output logic        busy
);

    localparam int BEEP_CYCLES = BEEP_SECS * TICKS_PER_SEC;
    localparam int BEEP_W      = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

    state_t            state;
    logic [SLOT_W-1:0] slot_table [NUM_SLOTS];
    logic [2:0]        slot_count;
    logic [1:0]        next_idx;
    logic              last_slot;

    logic              beep_clear;
    logic              beep_load;
    logic              beep_dec;
    logic              beep_zero;

    assign next_idx  = slot_idx + 2'd1;
    assign last_slot = ({1'b0, slot_idx} == (slot_count - 3'd1));

    // Beep counter is armed on a mid-sequence timer_done and counts the BEEP
    // state down to zero; a cancel wipes it so a later beep starts clean.
    always_comb begin
        beep_clear = 1'b0;
        beep_load  = 1'b0;
        beep_dec   = 1'b0;
        if (cancel && (state != ST_IDLE)) begin
            beep_clear = 1'b1;
        end else if ((state == ST_RUN) && timer_done && !last_slot) begin
            beep_load = 1'b1;
        end else if ((state == ST_BEEP) && !beep_zero) begin
            beep_dec = 1'b1;
        end
    end

    beep_counter #(
        .WIDTH (BEEP_W)
    ) u_beep_counter (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (beep_clear),
        .load       (beep_load),
        .load_value (BEEP_LAST),
        .dec        (beep_dec),
        .zero       (beep_zero)
    );

    // Main sequencer: state, interval table and all registered outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            load       <= 1'b0;
            load_mins  <= '0;
            run        <= 1'b0;
            alarm_on   <= 1'b0;
            slot_idx   <= 2'd0;
            busy       <= 1'b0;
            slot_count <= MIN_COUNT;
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_table[i] <= MIN_MINS;
        end else begin
            load      <= 1'b0;
            load_mins <= '0;
            case (state)
                ST_IDLE: begin
                    if (prog_we) begin
                        slot_table[prog_addr] <= clamp_mins(prog_mins);
                        slot_count            <= clamp_count(prog_count);
                    end
                    if (start) begin
                        state     <= ST_LOAD;
                        slot_idx  <= 2'd0;
                        load      <= 1'b1;
                        load_mins <= slot_table[0];
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cancel) begin
                        state    <= ST_IDLE;
                        slot_idx <= 2'd0;
                        run      <= 1'b0;
                        alarm_on <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                        run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state    <= ST_IDLE;
                        slot_idx <= 2'd0;
                        run      <= 1'b0;
                        alarm_on <= 1'b0;
                        busy     <= 1'b0;
                    end else if (timer_done) begin
                        state    <= last_slot ? ST_DONE : ST_BEEP;
                        run      <= 1'b0;
                        alarm_on <= 1'b1;
                    end else if (start) begin
                        state <= ST_PAUSED;
                        run   <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (cancel) begin
                        state    <= ST_IDLE;
                        slot_idx <= 2'd0;
                        run      <= 1'b0;
                        alarm_on <= 1'b0;
                        busy     <= 1'b0;
                    end else if (start) begin
                        state <= ST_RUN;
                        run   <= 1'b1;
                    end
                end
                ST_BEEP: begin
                    if (cancel) begin
                        state    <= ST_IDLE;
                        slot_idx <= 2'd0;
                        run      <= 1'b0;
                        alarm_on <= 1'b0;
                        busy     <= 1'b0;
                    end else if (beep_zero) begin
                        state     <= ST_LOAD;
                        alarm_on  <= 1'b0;
                        slot_idx  <= next_idx;
                        load      <= 1'b1;
                        load_mins <= slot_table[next_idx];
                    end
                end
                ST_DONE: begin
                    if (cancel || start) begin
                        state    <= ST_IDLE;
                        slot_idx <= 2'd0;
                        run      <= 1'b0;
                        alarm_on <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    slot_idx <= 2'd0;
                    run      <= 1'b0;
                    alarm_on <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
